// File: rtl/zeroriscy_d_pkg.sv
// Shared types and helpers for the zero-riscy data-SRAM line reader.
// Bank k of a line lives at bits [32*(7-k)+31 : 32*(7-k)].
package zeroriscy_d_pkg;

  localparam int LINE_WORDS = 8;
  localparam int WORD_W     = 32;
  localparam int LINE_W     = LINE_WORDS * WORD_W;
  localparam int ADDR_W     = 12;
  localparam int IDX_W      = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_SEND
  } state_e;

  function automatic logic [WORD_W-1:0] word_slice(input logic [LINE_W-1:0] i_line,
                                                   input logic [IDX_W-1:0]  i_k);
    return i_line[WORD_W*(LINE_WORDS-1-int'(i_k)) +: WORD_W];
  endfunction

endpackage

// File: rtl/zeroriscy_d_word_sel.sv
// Holds one captured SRAM line and presents it as a registered word stream,
// tracking bank index, words sent and the last-word flag.
module zeroriscy_d_word_sel
  import zeroriscy_d_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_load,
  input  logic [LINE_W-1:0] i_line,
  input  logic [IDX_W-1:0]  i_start,
  input  logic              i_advance,
  output logic [WORD_W-1:0] o_data,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_last
);

  logic [LINE_W-1:0] r_buf;
  logic [WORD_W-1:0] r_data;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  r_count;
  logic              r_last;
  logic [IDX_W-1:0]  w_next_idx;

  assign w_next_idx = r_idx + 3'd1;

  // NOTE: the line buffer is pure data storage with no reset; it is always
  // written by a capture before any word is marked valid.
  always_ff @(posedge i_clk) begin
    if (i_load) begin
      r_buf <= i_line;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_data  <= '0;
      r_idx   <= '0;
      r_count <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_data  <= word_slice(i_line, i_start);
      r_idx   <= i_start;
      r_count <= '0;
      r_last  <= 1'b0;
    end else if (i_advance) begin
      r_data  <= word_slice(r_buf, w_next_idx);
      r_idx   <= w_next_idx;
      r_count <= r_count + 3'd1;
      r_last  <= (r_count == 3'd6);
    end
  end

  assign o_data = r_data;
  assign o_idx  = r_idx;
  assign o_last = r_last;

endmodule

// File: rtl/zeroriscy_d_line_reader.sv
// Reads one 256-bit data-SRAM line and streams it as eight 32-bit words.
// Define ZERORISCY_D_LINE_CWF_EN for critical-word-first ordering from req_word.
module zeroriscy_d_line_reader
  import zeroriscy_d_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_req_line,
  input  logic [IDX_W-1:0]  i_req_word,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [7:0]        o_sram_cs,
  output logic              o_sram_we,
  output logic [3:0]        o_sram_be,
  output logic [31:0]       o_sram_din,
  input  logic [LINE_W-1:0] i_sram_dout,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [WORD_W-1:0] o_out_data,
  output logic [IDX_W-1:0]  o_out_idx,
  output logic              o_out_last,
  output logic              o_busy
);

  state_e            r_state;
  state_e            w_next_state;
  logic [ADDR_W-1:0] r_line;
  logic [IDX_W-1:0]  r_start;
  logic [IDX_W-1:0]  w_start;
  logic              w_accept;
  logic              w_advance;
  logic              w_load;

`ifdef ZERORISCY_D_LINE_CWF_EN
  assign w_start = i_req_word;
`else
  logic w_unused_req_word;
  assign w_unused_req_word = ^i_req_word;
  assign w_start           = '0;
`endif

  assign w_accept  = i_req_valid && o_req_ready;
  assign w_advance = o_out_valid && i_out_ready;
  assign w_load    = (r_state == ST_CAP);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_line  <= '0;
      r_start <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_line  <= i_req_line;
        r_start <= w_start;
      end
    end
  end

  // NOTE: every output of this block gets a default first so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    o_req_ready  = 1'b0;
    o_out_valid  = 1'b0;
    o_sram_cs    = 8'h00;
    case (r_state)
      ST_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) w_next_state = ST_RD;
      end
      ST_RD: begin
        o_sram_cs    = 8'hFF;
        w_next_state = ST_CAP;
      end
      ST_CAP: begin
        w_next_state = ST_SEND;
      end
      ST_SEND: begin
        o_out_valid = 1'b1;
        if (i_out_ready && o_out_last) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Read-only consumer of the wide port: write side held inactive.
  assign o_sram_addr = r_line;
  assign o_sram_we   = 1'b0;
  assign o_sram_be   = 4'h0;
  assign o_sram_din  = '0;
  assign o_busy      = (r_state != ST_IDLE);

  zeroriscy_d_word_sel u_word_sel (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_load    (w_load),
    .i_line    (i_sram_dout),
    .i_start   (r_start),
    .i_advance (w_advance),
    .o_data    (o_out_data),
    .o_idx     (o_out_idx),
    .o_last    (o_out_last)
  );

endmodule

// File: tb/tb_zeroriscy_d_line_reader.sv
// Scoreboard bench for zeroriscy_d_line_reader with a registered-read SRAM model.
module tb_zeroriscy_d_line_reader;
  import zeroriscy_d_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_line = '0;
  logic [2:0]        req_word = '0;
  logic [ADDR_W-1:0] sram_addr;
  logic [7:0]        sram_cs;
  logic              sram_we;
  logic [3:0]        sram_be;
  logic [31:0]       sram_din;
  logic [LINE_W-1:0] sram_dout;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [WORD_W-1:0] out_data;
  logic [2:0]        out_idx;
  logic              out_last;
  logic              busy;

  always #5 clk = ~clk;

  zeroriscy_d_line_reader dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_line  (req_line),
    .i_req_word  (req_word),
    .o_sram_addr (sram_addr),
    .o_sram_cs   (sram_cs),
    .o_sram_we   (sram_we),
    .o_sram_be   (sram_be),
    .o_sram_din  (sram_din),
    .i_sram_dout (sram_dout),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_out_idx   (out_idx),
    .o_out_last  (out_last),
    .o_busy      (busy)
  );

  // SRAM model: address registered on a chip-select cycle, data live from the array.
  logic [LINE_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] rd_addr = '0;
  always @(posedge clk) if (sram_cs != 8'h00) rd_addr <= sram_addr;
  assign sram_dout = mem[rd_addr];

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  idx;
    logic        last;
  } exp_t;

  exp_t sb[$];
  exp_t front;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   pops    = 0;
  int   cyc     = 0;
  int   last_pop_cyc = 0;
  bit   stall_mode = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_line(input logic [ADDR_W-1:0] line, input logic [2:0] w);
    logic [2:0] st;
    logic [2:0] k;
`ifdef ZERORISCY_D_LINE_CWF_EN
    st = w;
`else
    st = 3'd0;
`endif
    for (int i = 0; i < 8; i++) begin
      k = st + 3'(i);
      sb.push_back('{data: mem[line][32*(7-int'(k)) +: 32], idx: k, last: (i == 7)});
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      check("sram_wr_off", {27'd0, sram_we, sram_be, sram_din}, 64'd0);
      if (req_valid && req_ready) push_line(req_line, req_word);
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          front = sb[0];
          check("out_data", out_data, front.data);
          check("out_idx",  out_idx,  front.idx);
          check("out_last", out_last, front.last);
          if (out_ready) begin
            void'(sb.pop_front());
            pops++;
            if (front.last) last_pop_cyc = cyc;
          end
        end
      end
    end
  end

  initial begin : ready_drv
    int ph;
    bit [3:0] seq;
    ph  = 0;
    seq = 4'b1001;
    forever begin
      @(posedge clk);
      #1;
      if (stall_mode) begin
        out_ready = seq[3-ph];
        ph = (ph + 1) % 4;
      end else begin
        out_ready = 1'b1;
        ph = 0;
      end
    end
  end

  task automatic send_req(input logic [ADDR_W-1:0] line, input logic [2:0] w);
    int n;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_line  = line;
    req_word  = w;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 50);
    check("req_timeout", 64'(n >= 50), 64'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    check(tag, 64'(n >= 300), 64'd0);
  endtask

  initial begin
    int base;
    int n;
    for (int l = 0; l < (1 << ADDR_W); l++) mem[l] = '0;
    for (int k = 0; k < 8; k++) begin
      mem[12'h005][32*(7-k) +: 32] = 32'h1111_0000 + k;
      mem[12'h7FF][32*(7-k) +: 32] = 32'h7FF0_0000 + k;
      mem[12'h123][32*(7-k) +: 32] = 32'h1230_A000 + k;
    end

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data,  0);
    check("rst_out_idx",   out_idx,   0);
    check("rst_out_last",  out_last,  0);
    check("rst_busy",      busy,      0);
    check("rst_sram_cs",   sram_cs,   0);
    check("rst_sram_addr", sram_addr, 0);

    // Plain line read, latency and SRAM strobes.
    send_req(12'h005, 3'd0);
    @(negedge clk);
    check("rd_out_valid", out_valid, 0);
    check("rd_req_ready", req_ready, 0);
    check("rd_sram_cs",   sram_cs,   8'hFF);
    check("rd_sram_addr", sram_addr, 12'h005);
    @(negedge clk);
    check("cap_out_valid", out_valid, 0);
    check("cap_sram_cs",   sram_cs,   0);
    @(negedge clk);
    check("first_valid",   out_valid, 1);
    wait_idle("t1_drain");
    check("addr_hold", sram_addr, 12'h005);

    // Back-pressure: each word held stable while stalled.
    base = pops;
    stall_mode = 1'b1;
    send_req(12'h005, 3'd0);
    wait_idle("t2_drain");
    stall_mode = 1'b0;
    check("t2_word_count", pops - base, 8);

    // Start word request (honoured only in the critical-word-first build).
    send_req(12'h005, 3'd5);
    wait_idle("t3_drain");

    // SRAM write during SEND does not reach the stream.
    send_req(12'h005, 3'd0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t4_valid_timeout", 64'(n >= 20), 64'd0);
    mem[12'h005][32*5 +: 32] = 32'hDEAD_BEEF;
    wait_idle("t4_drain");
    mem[12'h005][32*5 +: 32] = 32'h1111_0002;

    // Reset mid-line after word 3 is accepted.
    base = pops;
    send_req(12'h005, 3'd0);
    n = 0;
    while (pops < base + 4 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    check("t5_pop_timeout", 64'(n >= 50), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("t5_out_valid", out_valid, 0);
    check("t5_req_ready", req_ready, 1);
    check("t5_busy",      busy,      0);
    check("t5_out_idx",   out_idx,   0);
    send_req(12'h7FF, 3'd0);
    wait_idle("t5_drain");

    // Back-to-back requests with req_valid held high.
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_line  = 12'h005;
    req_word  = 3'd0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 50);
    @(posedge clk); #1;
    req_line = 12'h123;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 100);
    check("t6_idle_timeout", 64'(n >= 100), 64'd0);
    check("t6_idle_ready", req_ready, 1);
    check("t6_idle_entry", cyc, last_pop_cyc + 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("t6_accept_busy", busy,      1);
    check("t6_accept_cs",   sram_cs,   8'hFF);
    check("t6_accept_addr", sram_addr, 12'h123);
    wait_idle("t6_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
